// File: rtl/nanorv32_irq_ctrl.sv
// rtl/nanorv32_irq_ctrl.sv - edge-triggered interrupt controller with single irq/ack/reti handshake
// Optional macro NANORV32_IRQ_SYNC_EN adds a 2-flop synchronizer on irq_src.
module nanorv32_irq_ctrl #(
  parameter int NB_IRQ = 16,
  parameter int ID_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NB_IRQ-1:0] i_irq_src,
  output logic              o_irq,
  output logic [ID_W-1:0]   o_irq_id,
  input  logic              i_irq_ack,
  input  logic              i_reti_done,
  input  logic              i_reg_sel,
  input  logic              i_reg_wr,
  input  logic [1:0]        i_reg_addr,
  input  logic [31:0]       i_reg_wdata,
  output logic [31:0]       o_reg_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_irq;
  logic [ID_W-1:0]   r_irq_id;
  logic [31:0]       r_rdata;
  logic [NB_IRQ-1:0] r_enable;
  logic [NB_IRQ-1:0] r_pending;
  logic [NB_IRQ-1:0] r_src_prev;

  logic [NB_IRQ-1:0] w_src;
  logic [NB_IRQ-1:0] w_rise;
  logic [NB_IRQ-1:0] w_cand;
  logic [NB_IRQ-1:0] w_wdata;
  logic [NB_IRQ-1:0] w_set;
  logic [NB_IRQ-1:0] w_clr;
  logic [NB_IRQ-1:0] w_pend_next;
  logic [ID_W-1:0]   w_sel;
  logic [31:0]       w_rd_mux;
  logic              w_wr;
  logic              w_unused;

`ifdef NANORV32_IRQ_SYNC_EN
  logic [NB_IRQ-1:0] r_sync1;
  logic [NB_IRQ-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = i_irq_src;
`endif

  assign w_unused = &{1'b0, i_reg_wdata};
  assign w_wdata  = i_reg_wdata[NB_IRQ-1:0];
  assign w_wr     = i_reg_sel && i_reg_wr;
  assign w_rise   = w_src & ~r_src_prev;
  assign w_cand   = r_pending & r_enable;

  // Sets (edges, SWSET) are applied after clears so a same-cycle set wins.
  assign w_set = w_rise | ((w_wr && i_reg_addr == 2'd3) ? w_wdata : '0);
  assign w_clr = ((w_wr && i_reg_addr == 2'd1) ? w_wdata : '0)
               | ((r_state == S_REQ && i_irq_ack) ? (NB_IRQ'(1) << r_irq_id) : '0);
  assign w_pend_next = (r_pending & ~w_clr) | w_set;

  always_comb begin
    w_sel = '0;
    for (int i = NB_IRQ - 1; i >= 0; i--) begin
      if (w_cand[i]) w_sel = ID_W'(i);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (i_reg_addr)
      2'd0: w_rd_mux[NB_IRQ-1:0] = r_enable;
      2'd1: w_rd_mux[NB_IRQ-1:0] = r_pending;
      2'd2: begin
        w_rd_mux[9:8]      = r_state;
        w_rd_mux[ID_W-1:0] = r_irq_id;
      end
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_irq      <= 1'b0;
      r_irq_id   <= '0;
      r_rdata    <= '0;
      r_enable   <= '0;
      r_pending  <= '0;
      r_src_prev <= '0;
    end else begin
      r_src_prev <= w_src;
      r_pending  <= w_pend_next;
      if (w_wr && i_reg_addr == 2'd0) r_enable <= w_wdata;
      if (i_reg_sel && !i_reg_wr) r_rdata <= w_rd_mux;

      case (r_state)
        S_IDLE: begin
          if (|w_cand) begin
            r_irq_id <= w_sel;
            r_irq    <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_irq_ack) begin
            r_irq   <= 1'b0;
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (i_reti_done) r_state <= S_IDLE;
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_irq       = r_irq;
  assign o_irq_id    = r_irq_id;
  assign o_reg_rdata = r_rdata;

endmodule

// File: tb/tb_nanorv32_irq_ctrl.sv
// tb/tb_nanorv32_irq_ctrl.sv - directed self-checking bench for nanorv32_irq_ctrl
// Honors NANORV32_IRQ_SYNC_EN for the expected edge-to-irq latency.
module tb_nanorv32_irq_ctrl;

`ifdef NANORV32_IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] irq_src = '0;
  logic        irq;
  logic [4:0]  irq_id;
  logic        irq_ack = 1'b0;
  logic        reti_done = 1'b0;
  logic        reg_sel = 1'b0;
  logic        reg_wr = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  nanorv32_irq_ctrl #(.NB_IRQ(16), .ID_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_irq_src  (irq_src),
    .o_irq      (irq),
    .o_irq_id   (irq_id),
    .i_irq_ack  (irq_ack),
    .i_reti_done(reti_done),
    .i_reg_sel  (reg_sel),
    .i_reg_wr   (reg_wr),
    .i_reg_addr (reg_addr),
    .i_reg_wdata(reg_wdata),
    .o_reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
    reg_sel = 1'b1; reg_wr = 1'b1; reg_addr = addr; reg_wdata = data;
    tick();
    reg_sel = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] addr, output logic [31:0] data);
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = addr;
    tick();
    reg_sel = 1'b0;
    data = reg_rdata;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    reti_done = 1'b1; tick(); reti_done = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_irq", irq, 0);
    check("rst_id", irq_id, 0);
    check("rst_rdata", reg_rdata, 0);
    rst_n = 1'b1;
    tick();
    reg_read(2'd2, rd); check("rst_active", rd, 0);

    // Test 1: single source, full handshake
    reg_write(2'd0, 32'h0004);
    reg_read(2'd0, rd); check("t1_enable", rd, 32'h0004);
    irq_src[2] = 1'b1;
    repeat (LAT - 1) tick();
    check("t1_irq_early", irq, 0);
    tick();
    check("t1_irq", irq, 1);
    check("t1_id", irq_id, 2);
    reg_read(2'd2, rd); check("t1_active_req", rd, 32'h0102);
    pulse_ack();
    check("t1_irq_drop", irq, 0);
    reg_read(2'd1, rd); check("t1_pending", rd, 0);
    reg_read(2'd2, rd); check("t1_active_act", rd, 32'h0202);
    pulse_reti();
    reg_read(2'd2, rd); check("t1_active_idle", rd, 32'h0002);
    irq_src = '0;
    repeat (LAT + 1) tick();

    // Test 2: priority, upper enable bits masked, irq-low gap
    reg_write(2'd0, 32'hFFFF_FFFF);
    reg_read(2'd0, rd); check("t2_enable_mask", rd, 32'h0000_FFFF);
    irq_src[5] = 1'b1; irq_src[3] = 1'b1;
    repeat (LAT) tick();
    check("t2_irq_a", irq, 1);
    check("t2_id_a", irq_id, 3);
    pulse_ack();
    pulse_reti();
    check("t2_gap", irq, 0);
    tick();
    check("t2_irq_b", irq, 1);
    check("t2_id_b", irq_id, 5);
    pulse_ack();
    pulse_reti();
    irq_src = '0;
    repeat (LAT + 1) tick();

    // Test 3: masked source stays pending until enabled
    reg_write(2'd0, 32'h0);
    irq_src[7] = 1'b1;
    repeat (LAT + 1) tick();
    reg_read(2'd1, rd); check("t3_pending", rd, 32'h0080);
    check("t3_irq_masked", irq, 0);
    reg_write(2'd0, 32'h0080);
    check("t3_irq_wait", irq, 0);
    tick();
    check("t3_irq", irq, 1);
    check("t3_id", irq_id, 7);
    pulse_ack();
    pulse_reti();
    irq_src = '0;
    repeat (LAT + 1) tick();

    // Test 4: request not withdrawn by clear; set wins in ack cycle
    reg_write(2'd0, 32'h0002);
    irq_src[1] = 1'b1;
    repeat (LAT) tick();
    check("t4_irq", irq, 1);
    check("t4_id", irq_id, 1);
    irq_src[1] = 1'b0;
    reg_write(2'd1, 32'h0002);
    check("t4_irq_hold", irq, 1);
    irq_src[1] = 1'b1;
    pulse_ack();
    check("t4_irq_drop", irq, 0);
    repeat (LAT - 2) tick();
    reg_read(2'd1, rd); check("t4_pending_set", rd, 32'h0002);
    pulse_reti();
    check("t4_gap", irq, 0);
    tick();
    check("t4_rearb", irq, 1);
    pulse_ack();
    pulse_reti();
    irq_src = '0;

    // Test 5: stray ack/reti in IDLE, SWSET, reset in ACTIVE
    reg_write(2'd0, 32'h0);
    reg_write(2'd1, 32'hFFFF_FFFF);
    repeat (LAT + 1) tick();
    pulse_ack();
    pulse_reti();
    check("t5_idle_irq", irq, 0);
    reg_read(2'd2, rd); check("t5_idle_active", rd, 32'h0001);
    reg_read(2'd1, rd); check("t5_idle_pending", rd, 0);
    reg_write(2'd0, 32'h0010);
    reg_write(2'd3, 32'h0010);
    check("t5_sw_wait", irq, 0);
    tick();
    check("t5_sw_irq", irq, 1);
    check("t5_sw_id", irq_id, 4);
    reg_read(2'd3, rd); check("t5_swset_read", rd, 0);
    pulse_ack();
    reg_read(2'd2, rd); check("t5_active", rd, 32'h0204);
    rst_n = 1'b0;
    #1;
    check("t5_rst_irq", irq, 0);
    check("t5_rst_id", irq_id, 0);
    check("t5_rst_rdata", reg_rdata, 0);
    tick();
    rst_n = 1'b1;
    tick();
    reg_read(2'd0, rd); check("t5_rst_enable", rd, 0);
    reg_read(2'd1, rd); check("t5_rst_pending", rd, 0);
    reg_read(2'd2, rd); check("t5_rst_active", rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nanorv32_irq_ctrl.md
Name: nanorv32_irq_ctrl

Overview:
Interrupt controller that generates the core's single irq request and receives the return notifications from the core's pipeline control. It edge-detects up to NB_IRQ peripheral sources, latches them as pending, masks them with a software enable register, and presents one request at a time. It holds irq high until the core acknowledges the request, then waits for the core's return-from-interrupt before arbitrating again. It sits beside the core and is configured through a simple single-cycle register port.

Parameters:
NB_IRQ, 16, number of interrupt sources (1..32)
ID_W, 5, width of irq_id; must satisfy 2**ID_W >= NB_IRQ

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
irq_src  input  NB_IRQ  peripheral interrupt lines; a rising edge marks the source pending
irq  output  1  interrupt request to the core
irq_id  output  ID_W  index of the source being requested or serviced
irq_ack  input  1  one-cycle pulse from the core when it enters its IRQ entry sequence
reti_done  input  1  one-cycle pulse from the core when its RETI exit sequence completes
reg_sel  input  1  register access strobe
reg_wr  input  1  1 = write, 0 = read (valid with reg_sel)
reg_addr  input  2  register index
reg_wdata  input  32  write data
reg_rdata  output  32  read data, registered, valid the cycle after reg_sel

Behaviour:
- Reset values: irq=0, irq_id=0, reg_rdata=0, enable=0, pending=0, src_prev=0, state=IDLE.
- Edge detect: src_prev <= irq_src each cycle. rise = irq_src & ~src_prev. A set bit in rise sets the matching pending bit.
- Register map, bits at and above NB_IRQ read 0 and ignore writes:
  - 0 ENABLE, read/write.
  - 1 PENDING, read; write-one-to-clear.
  - 2 ACTIVE, read: {state[1:0] at bits 9:8, irq_id at bits ID_W-1:0}.
  - 3 SWSET, write-one-to-set pending; reads 0.
- Same-cycle set and clear on one pending bit: set wins.
- cand = pending & enable. The selected source is the lowest set index of cand.
- FSM:
  - IDLE: if cand != 0, latch irq_id = selected source and go to REQ; irq rises in the cycle after cand becomes non-zero. Otherwise stay in IDLE.
  - REQ: irq=1, irq_id frozen. Clearing enable or pending in this state does not withdraw the request. On irq_ack, clear pending[irq_id], drop irq to 0 in the next cycle, and go to ACTIVE. A new edge on the same source in the ack cycle sets pending again (set wins).
  - ACTIVE: irq=0, irq_id held. On reti_done, go to IDLE. Re-arbitration starts no earlier than the cycle after reti_done, so there is at least one irq-low cycle between requests.
- irq_ack while in IDLE or ACTIVE is ignored. reti_done while in IDLE or REQ is ignored.
- There is no nesting: a higher-priority edge arriving during REQ or ACTIVE only becomes pending.
- irq is a flop output, with no combinational path from irq_src or irq_ack.
- A reset mid-operation returns to IDLE with all state cleared. Edges seen while rst_n is low are lost.

Optional Feature:
NANORV32_IRQ_SYNC_EN:
- Defined: irq_src passes through a 2-flop synchronizer, reset to 0, before edge detection. Edge-to-irq latency becomes 4 cycles.
- Undefined: irq_src is assumed synchronous to clk. Edge-to-irq latency is 2 cycles (edge registered into pending, then the FSM moves to REQ).

Test Plan:
1. Write ENABLE=0x0004, raise irq_src[2] at cycle t -> irq=1 with irq_id=2 at t+2. Pulse irq_ack -> irq=0 the next cycle and PENDING reads 0. Pulse reti_done -> state returns to IDLE.
2. ENABLE=0xFFFF, rise irq_src[5] and irq_src[3] in the same cycle -> irq_id=3 first. After ack and reti_done, irq_id=5 is requested; the gap has at least one cycle with irq=0.
3. ENABLE=0, rise irq_src[7] -> PENDING=0x0080, irq stays 0. Then write ENABLE=0x0080 -> irq=1 with irq_id=7 two cycles later.
4. During REQ for id 1, write PENDING=0x0002 (clear) -> irq stays 1 until irq_ack. Then in the ack cycle, rise irq_src[1] again -> PENDING bit 1 reads 1 after the ack.
5. Apply irq_ack and reti_done pulses while in IDLE -> no state change and irq stays 0. Also assert rst_n low while in ACTIVE -> all registers return to 0 and irq=0.
6. With NANORV32_IRQ_SYNC_EN defined, repeat test 1 -> irq rises at t+4.
